// File: rtl/vai_reg_initiator.sv
// VAI register-access initiator: turns single read/write commands into VAI request frames and collects the ack.
// Optional response timeout is enabled by defining VAI_INITIATOR_TIMEOUT_EN.
module vai_reg_initiator #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       Clk_i,
  input  logic       Reset_n_i,
  input  logic       CmdValid_i,
  output logic       CmdAccept_o,
  input  logic       CmdWrite_i,
  input  logic [3:0] CmdAddr_i,
  input  logic [7:0] CmdData_i,
  output logic       RspValid_o,
  input  logic       RspAccept_i,
  output logic [7:0] RspData_o,
  output logic       RspError_o,
  output logic       RspProtErr_o,
  output logic [7:0] Dout_o,
  output logic       DoutValid_o,
  output logic       DoutStart_o,
  output logic       DoutStop_o,
  input  logic       DoutAccept_i,
  input  logic [7:0] Din_i,
  input  logic       DinValid_i,
  input  logic       DinStart_i,
  input  logic       DinStop_i,
  output logic       DinAccept_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HEADER,
    S_SEND_DATA,
    S_GET_HEADER,
    S_GET_DATA,
    S_GET_FOOTER,
    S_RESPOND
  } state_t;

  // Out-of-range TIMEOUT is rejected at elaboration rather than silently wrapping the counter.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("vai_reg_initiator: TIMEOUT must be in 2..65535");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_hdr;
  logic [7:0]  r_data;
  logic        r_write;
  logic [7:0]  r_dout;
  logic        r_dout_valid;
  logic        r_dout_start;
  logic        r_dout_stop;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_err;
  logic        r_prot_err;

  logic        w_cmd_fire;
  logic        w_dout_fire;
  logic        w_din_fire;
  logic        w_in_get;
  logic        w_timeout;

  assign w_in_get    = (r_state == S_GET_HEADER) || (r_state == S_GET_DATA) ||
                       (r_state == S_GET_FOOTER);
  assign w_cmd_fire  = CmdValid_i && (r_state == S_IDLE);
  assign w_dout_fire = r_dout_valid && DoutAccept_i;
  assign w_din_fire  = DinValid_i && w_in_get;

`ifdef VAI_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_tmo_cnt;

  // Counter restarts on every accepted ack beat; a beat in the expiry cycle wins over the timeout.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i)                 r_tmo_cnt <= '0;
    else if (!w_in_get || w_din_fire) r_tmo_cnt <= '0;
    else                            r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  assign w_timeout = w_in_get && !w_din_fire && (r_tmo_cnt == TMO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:        if (CmdValid_i) w_state_nxt = S_SEND_HEADER;
      S_SEND_HEADER: if (w_dout_fire) w_state_nxt = r_write ? S_SEND_DATA : S_GET_HEADER;
      S_SEND_DATA:   if (w_dout_fire) w_state_nxt = S_GET_HEADER;
      S_GET_HEADER: begin
        if (w_timeout)       w_state_nxt = S_RESPOND;
        else if (w_din_fire) w_state_nxt = r_write ? S_GET_FOOTER : S_GET_DATA;
      end
      S_GET_DATA: begin
        if (w_timeout)       w_state_nxt = S_RESPOND;
        else if (w_din_fire) w_state_nxt = S_GET_FOOTER;
      end
      S_GET_FOOTER:  if (w_timeout || w_din_fire) w_state_nxt = S_RESPOND;
      S_RESPOND:     if (RspAccept_i) w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // Request beats are registered; data beat is loaded one cycle after the header leaves, giving the gap.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_hdr        <= '0;
      r_data       <= '0;
      r_write      <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_start <= 1'b0;
      r_dout_stop  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_prot_err   <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_hdr        <= {CmdAddr_i, 3'b000, CmdWrite_i};
        r_data       <= CmdData_i;
        r_write      <= CmdWrite_i;
        r_dout       <= {CmdAddr_i, 3'b000, CmdWrite_i};
        r_dout_valid <= 1'b1;
        r_dout_start <= 1'b1;
        r_dout_stop  <= !CmdWrite_i;
        r_rsp_data   <= '0;
        r_rsp_err    <= 1'b0;
        r_prot_err   <= 1'b0;
      end
      if ((r_state == S_SEND_HEADER || r_state == S_SEND_DATA) && w_dout_fire) begin
        r_dout       <= '0;
        r_dout_valid <= 1'b0;
        r_dout_start <= 1'b0;
        r_dout_stop  <= 1'b0;
      end else if (r_state == S_SEND_DATA && !r_dout_valid) begin
        r_dout       <= r_data;
        r_dout_valid <= 1'b1;
        r_dout_stop  <= 1'b1;
      end
      if (w_din_fire) begin
        case (r_state)
          S_GET_HEADER:
            if (!DinStart_i || DinStop_i || (Din_i != r_hdr)) r_prot_err <= 1'b1;
          S_GET_DATA: begin
            r_rsp_data <= Din_i;
            if (DinStart_i || DinStop_i) r_prot_err <= 1'b1;
          end
          S_GET_FOOTER: begin
            r_rsp_err <= Din_i[0];
            if (!DinStop_i || DinStart_i) r_prot_err <= 1'b1;
          end
          default: ;
        endcase
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
        r_prot_err <= 1'b1;
      end
    end
  end

  assign CmdAccept_o  = (r_state == S_IDLE);
  assign DinAccept_o  = w_in_get;
  assign RspValid_o   = (r_state == S_RESPOND);
  assign RspData_o    = r_rsp_data;
  assign RspError_o   = r_rsp_err;
  assign RspProtErr_o = r_prot_err;
  assign Dout_o       = r_dout;
  assign DoutValid_o  = r_dout_valid;
  assign DoutStart_o  = r_dout_start;
  assign DoutStop_o   = r_dout_stop;

endmodule
